hdmi_text_axi_vram_ctrl: RTL and testbench

AXI4-Lite slave front-end and access scheduler for the HDMI text controller's video memory. Accepts master read/write transactions, schedules them one at a time onto the single AXI-side port of the VRAM block RAM (600 words) or the control register (word 600), and applies per-byte write strobes. Sits between the AXI interconnect and the VRAM/control register; the draw side of the controller uses the other BRAM port and is not arbitrated here.

---
 rtl/hdmi_text_pkg.sv | 32 +++
 rtl/hdmi_text_ctrl_reg.sv | 23 ++
 rtl/hdmi_text_axi_vram_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_hdmi_text_axi_vram_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_text_pkg.sv
// Shared types and constants for the HDMI text controller's AXI-side VRAM access path.
package hdmi_text_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_COLLECT,
    WR_EXEC,
    WR_RESP,
    RD_ISSUE,
    RD_WAIT,
    RD_CAPT,
    RD_RESP
  } state_t;

  typedef enum logic {
    GRANT_READ,
    GRANT_WRITE
  } grant_t;

  typedef enum logic [1:0] {
    TGT_VRAM,
    TGT_CTRL,
    TGT_BAD
  } tgt_t;

  localparam int VRAM_WORDS = 600;
  localparam int CTRL_INDEX = VRAM_WORDS;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/hdmi_text_ctrl_reg.sv
// Byte-strobed 32-bit control register holding the text foreground/background colours.
module hdmi_text_ctrl_reg
  import hdmi_text_pkg::*;
(
  input  logic        clk,
  input  logic        arstn,
  input  logic        we,
  input  logic [3:0]  strb,
  input  logic [31:0] wdata,
  output logic [31:0] q
);

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      q <= '0;
    end else if (we) begin
      for (int k = 0; k < 4; k++) begin
        if (strb[k]) q[8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/hdmi_text_axi_vram_ctrl.sv
// AXI4-Lite slave that serialises master reads/writes onto the AXI-side VRAM BRAM port
// and the control register, one transaction at a time with round-robin arbitration.
module hdmi_text_axi_vram_ctrl #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 16,
  parameter int VRAM_WORDS       = hdmi_text_pkg::VRAM_WORDS
) (
  input  logic                          axi_aclk,
  input  logic                          axi_aresetn,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   axi_awaddr,
  input  logic [2:0]                    axi_awprot,
  input  logic                          axi_awvalid,
  output logic                          axi_awready,
  input  logic [C_AXI_DATA_WIDTH-1:0]   axi_wdata,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] axi_wstrb,
  input  logic                          axi_wvalid,
  output logic                          axi_wready,
  output logic [1:0]                    axi_bresp,
  output logic                          axi_bvalid,
  input  logic                          axi_bready,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   axi_araddr,
  input  logic [2:0]                    axi_arprot,
  input  logic                          axi_arvalid,
  output logic                          axi_arready,
  output logic [C_AXI_DATA_WIDTH-1:0]   axi_rdata,
  output logic [1:0]                    axi_rresp,
  output logic                          axi_rvalid,
  input  logic                          axi_rready,
  output logic                          vram_en,
  output logic [3:0]                    vram_we,
  output logic [9:0]                    vram_addr,
  output logic [31:0]                   vram_wdata,
  input  logic [31:0]                   vram_rdata,
  output logic [31:0]                   ctrl_reg
);
  import hdmi_text_pkg::*;

  state_t      state;
  grant_t      last_grant;
  logic        aw_got, w_got;
  logic [9:0]  aw_idx_q, ar_idx_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;

  logic        grant_wr, grant_rd;
  logic        aw_hs, w_hs, aw_have, w_have;
  logic [9:0]  eff_idx;
  logic [31:0] eff_wdata;
  logic [3:0]  eff_wstrb;
  logic        ctrl_we;

  function automatic tgt_t decode(input logic [9:0] idx);
    if (idx < 10'(VRAM_WORDS))       return TGT_VRAM;
    else if (idx == 10'(VRAM_WORDS)) return TGT_CTRL;
    else                             return TGT_BAD;
  endfunction

  // Arbitration and channel readies are combinational so a grant costs no extra cycle.
  assign grant_wr = (state == IDLE) && (axi_awvalid || axi_wvalid) &&
                    (!axi_arvalid || last_grant == GRANT_READ);
  assign grant_rd = (state == IDLE) && axi_arvalid && !grant_wr;

  assign axi_awready = axi_aresetn &&
                       ((grant_wr && axi_awvalid) || (state == WR_COLLECT && !aw_got));
  assign axi_wready  = axi_aresetn &&
                       ((grant_wr && axi_wvalid)  || (state == WR_COLLECT && !w_got));
  assign axi_arready = axi_aresetn && grant_rd;

  assign aw_hs   = axi_awvalid && axi_awready;
  assign w_hs    = axi_wvalid  && axi_wready;
  assign aw_have = aw_got || aw_hs;
  assign w_have  = w_got  || w_hs;

  // A channel captured earlier comes from its holding register, otherwise straight from the bus.
  assign eff_idx   = aw_got ? aw_idx_q : axi_awaddr[11:2];
  assign eff_wdata = w_got  ? wdata_q  : axi_wdata[31:0];
  assign eff_wstrb = w_got  ? wstrb_q  : axi_wstrb[3:0];

  assign ctrl_we = (state == WR_EXEC) && (decode(aw_idx_q) == TGT_CTRL);

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state      <= IDLE;
      last_grant <= GRANT_READ;
      aw_got     <= 1'b0;
      w_got      <= 1'b0;
      aw_idx_q   <= '0;
      ar_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      axi_bvalid <= 1'b0;
      axi_bresp  <= RESP_OKAY;
      axi_rvalid <= 1'b0;
      axi_rresp  <= RESP_OKAY;
      axi_rdata  <= '0;
      vram_en    <= 1'b0;
      vram_we    <= '0;
      vram_addr  <= '0;
      vram_wdata <= '0;
    end else begin
      if (aw_hs) begin
        aw_got   <= 1'b1;
        aw_idx_q <= axi_awaddr[11:2];
      end
      if (w_hs) begin
        w_got   <= 1'b1;
        wdata_q <= axi_wdata[31:0];
        wstrb_q <= axi_wstrb[3:0];
      end

      case (state)
        IDLE: begin
          if (grant_wr) begin
            last_grant <= GRANT_WRITE;
            if (aw_have && w_have) begin
              vram_en    <= (decode(eff_idx) == TGT_VRAM);
              vram_we    <= (decode(eff_idx) == TGT_VRAM) ? eff_wstrb : 4'b0000;
              vram_addr  <= eff_idx;
              vram_wdata <= eff_wdata;
              state      <= WR_EXEC;
            end else begin
              state <= WR_COLLECT;
            end
          end else if (grant_rd) begin
            last_grant <= GRANT_READ;
            ar_idx_q   <= axi_araddr[11:2];
            vram_en    <= 1'b1;
            vram_we    <= 4'b0000;
            vram_addr  <= axi_araddr[11:2];
            state      <= RD_ISSUE;
          end
        end
        WR_COLLECT: begin
          if (aw_have && w_have) begin
            vram_en    <= (decode(eff_idx) == TGT_VRAM);
            vram_we    <= (decode(eff_idx) == TGT_VRAM) ? eff_wstrb : 4'b0000;
            vram_addr  <= eff_idx;
            vram_wdata <= eff_wdata;
            state      <= WR_EXEC;
          end
        end
        WR_EXEC: begin
          vram_en    <= 1'b0;
          vram_we    <= 4'b0000;
          aw_got     <= 1'b0;
          w_got      <= 1'b0;
          axi_bvalid <= 1'b1;
          axi_bresp  <= (decode(aw_idx_q) == TGT_BAD) ? RESP_SLVERR : RESP_OKAY;
          state      <= WR_RESP;
        end
        WR_RESP: begin
          if (axi_bready) begin
            axi_bvalid <= 1'b0;
            state      <= IDLE;
          end
        end
        RD_ISSUE: begin
          vram_en <= 1'b0;
          state   <= RD_WAIT;
        end
        // BRAM output register makes data valid two cycles after the enable.
        RD_WAIT: state <= RD_CAPT;
        RD_CAPT: begin
          case (decode(ar_idx_q))
            TGT_VRAM: axi_rdata <= vram_rdata;
            TGT_CTRL: axi_rdata <= ctrl_reg;
            default:  axi_rdata <= '0;
          endcase
          axi_rresp  <= (decode(ar_idx_q) == TGT_BAD) ? RESP_SLVERR : RESP_OKAY;
          axi_rvalid <= 1'b1;
          state      <= RD_RESP;
        end
        RD_RESP: begin
          if (axi_rready) begin
            axi_rvalid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  hdmi_text_ctrl_reg u_ctrl_reg (
    .clk   (axi_aclk),
    .arstn (axi_aresetn),
    .we    (ctrl_we),
    .strb  (wstrb_q),
    .wdata (wdata_q),
    .q     (ctrl_reg)
  );

  logic unused_bits;
  assign unused_bits = &{1'b0, axi_awprot, axi_arprot,
                         axi_awaddr[C_AXI_ADDR_WIDTH-1:12], axi_awaddr[1:0],
                         axi_araddr[C_AXI_ADDR_WIDTH-1:12], axi_araddr[1:0]};

endmodule

// File: tb/tb_hdmi_text_axi_vram_ctrl.sv
// Directed and randomized bench for the AXI VRAM scheduler with a 2-cycle BRAM model.
module tb_hdmi_text_axi_vram_ctrl;

  logic        axi_aclk = 1'b0;
  logic        axi_aresetn = 1'b0;
  logic [15:0] axi_awaddr = '0;
  logic [2:0]  axi_awprot = '0;
  logic        axi_awvalid = 1'b0;
  logic        axi_awready;
  logic [31:0] axi_wdata = '0;
  logic [3:0]  axi_wstrb = '0;
  logic        axi_wvalid = 1'b0;
  logic        axi_wready;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready = 1'b0;
  logic [15:0] axi_araddr = '0;
  logic [2:0]  axi_arprot = '0;
  logic        axi_arvalid = 1'b0;
  logic        axi_arready;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rvalid;
  logic        axi_rready = 1'b0;
  logic        vram_en;
  logic [3:0]  vram_we;
  logic [9:0]  vram_addr;
  logic [31:0] vram_wdata;
  logic [31:0] vram_rdata;
  logic [31:0] ctrl_reg;

  int checks = 0;
  int errors = 0;
  int stray_we = 0;

  always #5 axi_aclk = ~axi_aclk;

  hdmi_text_axi_vram_ctrl dut (
    .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
    .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid),
    .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_araddr(axi_araddr), .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid),
    .axi_rready(axi_rready),
    .vram_en(vram_en), .vram_we(vram_we), .vram_addr(vram_addr),
    .vram_wdata(vram_wdata), .vram_rdata(vram_rdata), .ctrl_reg(ctrl_reg)
  );

  // Block RAM with output register: data appears two clocks after the enabled edge.
  logic [31:0] bram [0:599];
  logic [31:0] bram_q1, bram_q2;
  assign vram_rdata = bram_q2;

  always @(posedge axi_aclk) begin
    if (vram_en) begin
      if (vram_addr < 10'd600) begin
        for (int k = 0; k < 4; k++)
          if (vram_we[k]) bram[vram_addr][8*k +: 8] <= vram_wdata[8*k +: 8];
        bram_q1 <= bram[vram_addr];
      end else begin
        bram_q1 <= '0;
      end
      if (vram_we != 4'b0000 && vram_addr >= 10'd600) stray_we <= stray_we + 1;
    end
    bram_q2 <= bram_q1;
  end

  // Reference model of what the master should see.
  logic [31:0] ref_mem [0:599];
  logic [31:0] ref_ctrl = '0;

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old_v;
    for (int k = 0; k < 4; k++) if (strb[k]) r[8*k +: 8] = new_v[8*k +: 8];
    return r;
  endfunction

  function automatic int word_of(input logic [15:0] addr);
    return int'(addr[11:2]);
  endfunction

  function automatic logic [1:0] exp_resp(input logic [15:0] addr);
    return (word_of(addr) > 600) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [31:0] exp_read(input logic [15:0] addr);
    int w;
    w = word_of(addr);
    if (w < 600) return ref_mem[w];
    if (w == 600) return ref_ctrl;
    return 32'h0;
  endfunction

  task automatic model_write(input logic [15:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
    int w;
    w = word_of(addr);
    if (w < 600) ref_mem[w] = merge(ref_mem[w], data, strb);
    else if (w == 600) ref_ctrl = merge(ref_ctrl, data, strb);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered #1 after the last write handshake edge; leaves #1 after the B handshake edge.
  task automatic wait_b(input logic [1:0] eresp);
    int edges;
    edges = 0;
    forever begin
      @(negedge axi_aclk);
      if (axi_bvalid || edges > 40) break;
      @(posedge axi_aclk);
      edges++;
    end
    check("b_latency", 32'(edges + 1), 32'd2);
    check("bresp", 32'(axi_bresp), 32'(eresp));
    axi_bready = 1'b1;
    @(posedge axi_aclk); #1;
    axi_bready = 1'b0;
  endtask

  // Entered #1 after the AR handshake edge; optionally holds rready low for 'hold' cycles.
  task automatic wait_r(input logic [31:0] edata, input logic [1:0] eresp, input int hold);
    int edges;
    edges = 0;
    forever begin
      @(negedge axi_aclk);
      if (axi_rvalid || edges > 40) break;
      @(posedge axi_aclk);
      edges++;
    end
    check("r_latency", 32'(edges + 1), 32'd4);
    check("rresp", 32'(axi_rresp), 32'(eresp));
    check("rdata", axi_rdata, edata);
    for (int i = 0; i < hold; i++) begin
      @(negedge axi_aclk);
      check("r_hold_valid", 32'(axi_rvalid), 32'd1);
      check("r_hold_data", axi_rdata, edata);
    end
    axi_rready = 1'b1;
    @(posedge axi_aclk); #1;
    axi_rready = 1'b0;
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_dly);
    bit aw_done, w_done, hs_aw, hs_w;
    int c;
    aw_done = 0; w_done = 0; c = 0;
    @(posedge axi_aclk); #1;
    axi_wdata = data; axi_wstrb = strb; axi_wvalid = 1'b1;
    axi_awaddr = addr; axi_awvalid = (aw_dly == 0);
    while (!(aw_done && w_done) && c < 40) begin
      @(negedge axi_aclk);
      hs_aw = axi_awvalid && axi_awready;
      hs_w  = axi_wvalid && axi_wready;
      @(posedge axi_aclk); #1;
      if (hs_aw) begin aw_done = 1; axi_awvalid = 1'b0; end
      if (hs_w)  begin w_done = 1;  axi_wvalid = 1'b0; end
      c++;
      if (!aw_done && c == aw_dly) axi_awvalid = 1'b1;
    end
    check("w_handshakes", 32'({aw_done, w_done}), 32'd3);
    model_write(addr, data, strb);
    wait_b(exp_resp(addr));
    check("ctrl_reg", ctrl_reg, ref_ctrl);
  endtask

  task automatic do_read(input logic [15:0] addr, input int hold);
    bit hs;
    int c;
    c = 0; hs = 0;
    @(posedge axi_aclk); #1;
    axi_araddr = addr; axi_arvalid = 1'b1;
    while (!hs && c < 40) begin
      @(negedge axi_aclk);
      hs = axi_arvalid && axi_arready;
      @(posedge axi_aclk); #1;
      c++;
    end
    axi_arvalid = 1'b0;
    check("ar_handshake", 32'(hs), 32'd1);
    wait_r(exp_read(addr), exp_resp(addr), hold);
  endtask

  function automatic logic [15:0] rand_addr();
    int r, idx;
    r = $urandom_range(0, 99);
    if (r < 85) idx = $urandom_range(0, 599);
    else if (r < 92) idx = 600;
    else idx = $urandom_range(601, 1023);
    return {4'($urandom_range(0, 15)), 10'(idx), 2'($urandom_range(0, 3))};
  endfunction

  initial begin
    bit hs;
    int c;
    logic [15:0] a;

    // Outputs while reset is held.
    repeat (3) @(posedge axi_aclk);
    @(negedge axi_aclk);
    check("rst_readies", 32'({axi_awready, axi_wready, axi_arready}), 32'd0);
    check("rst_valids", 32'({axi_bvalid, axi_rvalid, axi_bresp, axi_rresp}), 32'd0);
    check("rst_rdata", axi_rdata, 32'd0);
    check("rst_ctrl", ctrl_reg, 32'd0);
    check("rst_vram", 32'({vram_en, vram_we, vram_addr}), 32'd0);
    check("rst_vwdata", vram_wdata, 32'd0);
    @(posedge axi_aclk); #1;
    axi_aresetn = 1'b1;

    // Control register write and readback.
    do_write(16'h0960, 32'h001F6000, 4'hF, 0);
    check("ctrl_first", ctrl_reg, 32'h001F6000);
    do_read(16'h0960, 0);

    // Fill and read back the whole VRAM.
    for (int i = 0; i < 600; i++) do_write(16'(4 * i), 32'(i), 4'hF, 0);
    for (int i = 0; i < 600; i++) do_read(16'(4 * i), 0);

    // Partial strobes.
    do_write(16'h0014, 32'hAABBCCDD, 4'hF, 0);
    do_write(16'h0014, 32'h11223344, 4'b0101, 0);
    check("strobe_model", exp_read(16'h0014), 32'hAA22CC44);
    do_read(16'h0014, 0);

    // Round robin: first contest to write, second to read.
    @(posedge axi_aclk); #1;
    axi_awaddr = 16'h0010; axi_wdata = 32'h5A5A0001; axi_wstrb = 4'hF;
    axi_awvalid = 1'b1; axi_wvalid = 1'b1;
    axi_araddr = 16'h0014; axi_arvalid = 1'b1;
    @(negedge axi_aclk);
    check("rr1_awready", 32'(axi_awready), 32'd1);
    check("rr1_arready", 32'(axi_arready), 32'd0);
    @(posedge axi_aclk); #1;
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    model_write(16'h0010, 32'h5A5A0001, 4'hF);
    wait_b(2'b00);
    axi_awaddr = 16'h0018; axi_wdata = 32'h5A5A0002;
    axi_awvalid = 1'b1; axi_wvalid = 1'b1;
    @(negedge axi_aclk);
    check("rr2_arready", 32'(axi_arready), 32'd1);
    check("rr2_awready", 32'(axi_awready), 32'd0);
    @(posedge axi_aclk); #1;
    axi_arvalid = 1'b0;
    wait_r(32'hAA22CC44, 2'b00, 0);
    hs = 0; c = 0;
    while (!hs && c < 20) begin
      @(negedge axi_aclk);
      hs = axi_awvalid && axi_awready && axi_wvalid && axi_wready;
      @(posedge axi_aclk); #1;
      c++;
    end
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    check("rr_pending_write", 32'(hs), 32'd1);
    model_write(16'h0018, 32'h5A5A0002, 4'hF);
    wait_b(2'b00);
    do_read(16'h0010, 0);
    do_read(16'h0018, 0);

    // W leads AW by three cycles.
    do_write(16'h0100, 32'hCAFEF00D, 4'hF, 3);
    do_read(16'h0100, 0);

    // Out-of-range word with a stalled read response.
    do_write(16'h0968, 32'hDEADBEEF, 4'hF, 0);
    do_read(16'h0968, 10);

    // Randomized mix against the model.
    for (int n = 0; n < 300; n++) begin
      a = rand_addr();
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
      else
        do_read(a, $urandom_range(0, 2));
    end

    // Reset during RD_WAIT.
    @(posedge axi_aclk); #1;
    axi_araddr = 16'h0020; axi_arvalid = 1'b1;
    @(negedge axi_aclk);
    check("rst_ar_grant", 32'(axi_arready), 32'd1);
    @(posedge axi_aclk); #1;
    axi_arvalid = 1'b0;
    @(posedge axi_aclk); #1;
    axi_aresetn = 1'b0;
    #1;
    check("mid_rst_valids", 32'({axi_bvalid, axi_rvalid, axi_arready, axi_awready}), 32'd0);
    check("mid_rst_rdata", axi_rdata, 32'd0);
    check("mid_rst_vram", 32'({vram_en, vram_we, vram_addr}), 32'd0);
    check("mid_rst_ctrl", ctrl_reg, 32'd0);
    ref_ctrl = '0;
    c = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge axi_aclk);
      if (axi_rvalid) c++;
    end
    @(posedge axi_aclk); #1;
    axi_aresetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge axi_aclk);
      if (axi_rvalid) c++;
    end
    check("no_abandoned_rvalid", 32'(c), 32'd0);
    do_read(16'h0020, 0);
    do_read(16'h0960, 0);

    check("stray_bram_writes", 32'(stray_we), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
